// File: rtl/kbd_seg_ctrl.sv
// Keyboard-experiment display sequencer: key events in, eight BCD/hex digit codes plus blank mask out.
// Optional time-multiplexed scan outputs are built only when SEG_SCAN_EN is defined.
module kbd_seg_ctrl #(
   parameter int unsigned SCAN_DIV   = 50000,
   parameter int unsigned LEAD_BLANK = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ev_valid,
   output logic        ev_ready,
   input  logic [7:0]  ev_code,
   input  logic [7:0]  ev_ascii,
   input  logic        ev_break,
   output logic [31:0] seg_num,
   output logic [7:0]  seg_blank,
   output logic [7:0]  scan_sel,
   output logic [3:0]  scan_num
);

   typedef enum logic [1:0] {StIdle, StHeld, StUpd} state_e;

   state_e      state_q, state_d;
   logic        tgt_held_q, tgt_held_d;
   logic [7:0]  held_q, held_d;
   logic [7:0]  ascii_q, ascii_d;
   logic [3:0]  ones_q, ones_d;
   logic [3:0]  tens_q, tens_d;
   logic [31:0] num_q, num_d;
   logic [7:0]  blank_q, blank_d;
   logic        accept;
   logic        bump;
   logic        tens_dark;

   assign ev_ready  = (state_q != StUpd);
   assign accept    = ev_valid & ev_ready;
   assign seg_num   = num_q;
   assign seg_blank = blank_q;
   assign tens_dark = (LEAD_BLANK != 0) && (tens_q == 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         tgt_held_q <= 1'b0;
         held_q     <= 8'h00;
         ascii_q    <= 8'h00;
         ones_q     <= 4'd0;
         tens_q     <= 4'd0;
         num_q      <= 32'h0;
         blank_q    <= 8'hFF;
      end else begin
         state_q    <= state_d;
         tgt_held_q <= tgt_held_d;
         held_q     <= held_d;
         ascii_q    <= ascii_d;
         ones_q     <= ones_d;
         tens_q     <= tens_d;
         num_q      <= num_d;
         blank_q    <= blank_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tgt_held_d = tgt_held_q;
      held_d     = held_q;
      ascii_d    = ascii_q;
      ones_d     = ones_q;
      tens_d     = tens_q;
      num_d      = num_q;
      blank_d    = blank_q;
      bump       = 1'b0;

      case (state_q)
         StIdle: begin
            if (accept && !ev_break) begin
               bump       = 1'b1;
               held_d     = ev_code;
               ascii_d    = ev_ascii;
               tgt_held_d = 1'b1;
               state_d    = StUpd;
            end
         end
         StHeld: begin
            if (accept) begin
               if (!ev_break) begin
                  // A repeat of the held code is typematic and does not count.
                  bump       = (ev_code != held_q);
                  held_d     = ev_code;
                  ascii_d    = ev_ascii;
                  tgt_held_d = 1'b1;
                  state_d    = StUpd;
               end else if (ev_code == held_q) begin
                  tgt_held_d = 1'b0;
                  state_d    = StUpd;
               end
            end
         end
         StUpd: begin
            state_d = tgt_held_q ? StHeld : StIdle;
            num_d   = {tens_q, ones_q, 8'h00, ascii_q, held_q};
            blank_d = {tens_dark, 1'b0, 2'b11,
                       tgt_held_q ? {{2{ascii_q == 8'h00}}, 2'b00} : 4'hF};
         end
         default: state_d = StIdle;
      endcase

      if (bump) begin
         if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

`ifdef SEG_SCAN_EN
   localparam int unsigned DivW = $clog2(SCAN_DIV);

   logic [DivW-1:0] div_q;
   logic [2:0]      idx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         idx_q <= 3'd0;
      end else if (div_q == DivW'(SCAN_DIV - 1)) begin
         div_q <= '0;
         idx_q <= idx_q + 3'd1;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   assign scan_sel = (8'd1 << idx_q) & ~blank_q;
   assign scan_num = num_q[{idx_q, 2'b00} +: 4];
`else
   assign scan_sel = 8'h00;
   assign scan_num = 4'h0;
`endif

endmodule
